// File: rtl/alu_shift_pkg.sv
// Shared types for the wide shift sequencer and its funnel.
// Holds the FSM state enum and the shift direction constants.
package alu_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

endpackage

// File: rtl/funnel_word.sv
// Combinational 64-to-32 funnel: one result word from a word pair.
// Ports: hi, lo (W), dir (1 = left), boff (bit offset) -> word (W).
module funnel_word
    import alu_shift_pkg::*;
#(
    parameter int W  = 32,
    parameter int BW = $clog2(W)
) (
    input  logic [W-1:0]  hi,
    input  logic [W-1:0]  lo,
    input  logic          dir,
    input  logic [BW-1:0] boff,
    output logic [W-1:0]  word
);

    localparam logic [BW-1:0] WM1 = BW'(W - 1);

    logic [BW-1:0] rb;
    logic [W-1:0]  left;
    logic [W-1:0]  right;

    // The cross-word part is shifted by 1 and then by W-1-boff.
    // This avoids a shift by W when boff is 0.
    assign rb    = WM1 - boff;
    assign left  = (hi << boff) | ((lo >> 1) >> rb);
    assign right = (lo >> boff) | ((hi << 1) << rb);
    assign word  = (dir == SHIFT_LEFT) ? left : right;

endmodule

// File: rtl/wide_shift_ctrl.sv
// Multi-word logical shifter producing one result word per clock.
// Ports: in_* request (valid/ready), out_* result (valid/ready), busy.
module wide_shift_ctrl
    import alu_shift_pkg::*;
#(
    parameter int W     = 32,
    parameter int WORDS = 4,
    parameter int AW    = $clog2(W * WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*WORDS-1:0]   in_data,
    input  logic                 in_dir,
    input  logic [AW-1:0]        in_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*WORDS-1:0]   out_data,
    output logic                 busy
);

    localparam int N  = W * WORDS;
    localparam int BW = $clog2(W);
    localparam int OW = AW - BW;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t        state;
    logic [N-1:0]  src;
    logic          dir;
    logic [OW-1:0] woff;
    logic [BW-1:0] boff;
    logic [IW-1:0] idx;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  word;

    // Words outside the operand read as zero instead of wrapping.
    function automatic logic [W-1:0] pick(input logic [N-1:0] s,
                                          input int k);
        if (k < 0 || k >= WORDS) return '0;
        return s[k*W +: W];
    endfunction

    always_comb begin
        int base;
        hi = '0;
        lo = '0;
        if (dir == SHIFT_LEFT) begin
            base = int'(idx) - int'(woff);
            hi   = pick(src, base);
            lo   = pick(src, base - 1);
        end else begin
            base = int'(idx) + int'(woff);
            lo   = pick(src, base);
            hi   = pick(src, base + 1);
        end
    end

    funnel_word #(.W(W), .BW(BW)) u_funnel (
        .hi   (hi),
        .lo   (lo),
        .dir  (dir),
        .boff (boff),
        .word (word)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            src       <= '0;
            dir       <= SHIFT_RIGHT;
            woff      <= '0;
            boff      <= '0;
            idx       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        src   <= in_data;
                        dir   <= in_dir;
                        woff  <= in_amt[AW-1:BW];
                        boff  <= in_amt[BW-1:0];
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    out_data[idx*W +: W] <= word;
                    idx <= idx + 1'b1;
                    if (idx == IW'(WORDS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
